// File: rtl/busy_table_ckpt_if.sv
// Dispatch/writeback/ROB-facing bundle for the checkpointed busy table.
// The master side drives the requests; the table sits on the slave side.
interface busy_table_ckpt_if #(
  parameter int NUM_PREG  = 64,
  parameter int NUM_RD    = 4,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_FREE  = 2,
  parameter int NUM_WALK  = 2,
  parameter int NUM_SNAP  = 4
);
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int SNAP_W = $clog2(NUM_SNAP);

  logic [NUM_RD*PREG_W-1:0]    rd_addr;
  logic [NUM_RD-1:0]           rd_busy;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr;
  logic [NUM_FREE-1:0]         free_en;
  logic [NUM_FREE*PREG_W-1:0]  free_addr;
  logic [NUM_WALK-1:0]         walk_en;
  logic [NUM_WALK*PREG_W-1:0]  walk_addr;
  logic                        rollback;
  logic                        snap_save_en;
  logic [SNAP_W-1:0]           snap_save_id;
  logic                        snap_rel_en;
  logic [SNAP_W-1:0]           snap_rel_id;
  logic                        snap_rst_en;
  logic [SNAP_W-1:0]           snap_rst_id;
  logic [NUM_SNAP-1:0]         snap_valid;
  logic                        snap_full;
  logic [PREG_W:0]             busy_cnt;

  modport master (
    output rd_addr, alloc_en, alloc_addr, free_en, free_addr, walk_en, walk_addr,
           rollback, snap_save_en, snap_save_id, snap_rel_en, snap_rel_id,
           snap_rst_en, snap_rst_id,
    input  rd_busy, snap_valid, snap_full, busy_cnt
  );

  modport slave (
    input  rd_addr, alloc_en, alloc_addr, free_en, free_addr, walk_en, walk_addr,
           rollback, snap_save_en, snap_save_id, snap_rel_en, snap_rel_id,
           snap_rst_en, snap_rst_id,
    output rd_busy, snap_valid, snap_full, busy_cnt
  );
endinterface

// File: rtl/busy_table_ckpt.sv
// Physical-register busy table with same-cycle bypassed reads and branch checkpoints
// that squash only the pregs allocated since the checkpoint was taken.
module busy_table_ckpt #(
  parameter int NUM_PREG  = 64,
  parameter int NUM_RD    = 4,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_FREE  = 2,
  parameter int NUM_WALK  = 2,
  parameter int NUM_SNAP  = 4,
  parameter int ZERO_PREG = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  busy_table_ckpt_if.slave  bus
);
  localparam int PREG_W = $clog2(NUM_PREG);
  localparam int SNAP_W = $clog2(NUM_SNAP);

  logic [NUM_PREG-1:0]               busy_q, busy_d;
  logic [NUM_SNAP-1:0][NUM_PREG-1:0] mask_q, mask_d;
  logic [NUM_SNAP-1:0]               snap_valid_q, snap_valid_d;

  logic [NUM_PREG-1:0] alloc_dec, free_dec, walk_dec, squash_mask;
  logic [NUM_SNAP-1:0] save_dec, rel_dec, rst_dec;
  logic                rst_hit;
  logic [NUM_RD-1:0]   rd_busy_c;
  logic [PREG_W:0]     busy_cnt_c;

  // Out-of-range addresses match no bit, so they are dropped on writes and read as 0.
  function automatic logic [NUM_PREG-1:0] decode_preg(input logic [PREG_W-1:0] addr);
    logic [NUM_PREG-1:0] dec;
    dec = '0;
    for (int p = 0; p < NUM_PREG; p++) begin
      if (addr == PREG_W'(p)) dec[p] = 1'b1;
    end
    return dec;
  endfunction

  function automatic logic [NUM_SNAP-1:0] decode_slot(input logic [SNAP_W-1:0] id);
    logic [NUM_SNAP-1:0] dec;
    dec = '0;
    for (int s = 0; s < NUM_SNAP; s++) begin
      if (id == SNAP_W'(s)) dec[s] = 1'b1;
    end
    return dec;
  endfunction

  always_comb begin
    alloc_dec = '0;
    free_dec  = '0;
    walk_dec  = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      if (bus.alloc_en[i]) alloc_dec = alloc_dec | decode_preg(bus.alloc_addr[i*PREG_W +: PREG_W]);
    end
    for (int i = 0; i < NUM_FREE; i++) begin
      if (bus.free_en[i]) free_dec = free_dec | decode_preg(bus.free_addr[i*PREG_W +: PREG_W]);
    end
    for (int i = 0; i < NUM_WALK; i++) begin
      if (bus.walk_en[i]) walk_dec = walk_dec | decode_preg(bus.walk_addr[i*PREG_W +: PREG_W]);
    end

    save_dec = bus.snap_save_en ? decode_slot(bus.snap_save_id) : '0;
    rel_dec  = bus.snap_rel_en  ? decode_slot(bus.snap_rel_id)  : '0;
    rst_dec  = bus.snap_rst_en  ? decode_slot(bus.snap_rst_id)  : '0;
    rst_hit  = |(rst_dec & snap_valid_q);

    squash_mask = '0;
    for (int s = 0; s < NUM_SNAP; s++) begin
      if (rst_dec[s] && snap_valid_q[s]) squash_mask = squash_mask | mask_q[s];
    end

    // Walk re-sets survive even a rollback; squash and free both beat a same-cycle alloc.
    busy_d = (busy_q | alloc_dec) & ~free_dec & ~squash_mask;
    if (bus.rollback) busy_d = '0;
    busy_d = busy_d | walk_dec;
    if (ZERO_PREG != 0) busy_d[0] = 1'b0;

    // Allocs in a save cycle are older than that checkpoint, so a saved slot starts empty.
    for (int s = 0; s < NUM_SNAP; s++) begin
      snap_valid_d[s] = snap_valid_q[s];
      mask_d[s]       = snap_valid_q[s] ? (mask_q[s] | alloc_dec) : mask_q[s];
      if (rel_dec[s]) begin
        snap_valid_d[s] = 1'b0;
        mask_d[s]       = '0;
      end
      if (save_dec[s]) begin
        snap_valid_d[s] = 1'b1;
        mask_d[s]       = '0;
      end
      if (bus.rollback || rst_hit) begin
        snap_valid_d[s] = 1'b0;
        mask_d[s]       = '0;
      end
    end
  end

  always_comb begin
    rd_busy_c = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_c[i] = |(decode_preg(bus.rd_addr[i*PREG_W +: PREG_W]) & busy_d);
    end
    busy_cnt_c = '0;
    for (int p = 0; p < NUM_PREG; p++) begin
      busy_cnt_c = busy_cnt_c + (PREG_W+1)'(busy_q[p]);
    end
  end

  assign bus.rd_busy    = rd_busy_c;
  assign bus.busy_cnt   = busy_cnt_c;
  assign bus.snap_valid = snap_valid_q;
  assign bus.snap_full  = &snap_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      mask_q       <= '0;
      snap_valid_q <= '0;
    end else begin
      busy_q       <= busy_d;
      mask_q       <= mask_d;
      snap_valid_q <= snap_valid_d;
    end
  end
endmodule
